// File: rtl/calc_pkg.sv
// Shared opcode values, sequencer state encoding and opcode helpers for the calculator controller.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_SQR = 3'b101;
    localparam logic [2:0] OP_CLR = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DIVW = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic is_div_op(input logic [2:0] f);
        return (f == OP_DIV) || (f == OP_MOD);
    endfunction

    // CLR and NOP retire without marking the accumulator as holding a chained value.
    function automatic logic sets_acc_valid(input logic [2:0] f);
        return (f != OP_CLR) && (f != OP_NOP);
    endfunction

endpackage

// File: rtl/calc_seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle over W cycles.
// div_done is high during the cycle whose edge produces the final quotient/remainder.
module calc_seq_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    logic [W:0] shifted_d;
    logic [W:0] trial_d;

    always_comb begin
        shifted_d = {rem_q, quo_q[W-1]};
        trial_d   = shifted_d - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= CW'(W);
            run_q <= 1'b1;
        end else if (run_q) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            if (!trial_d[W]) begin
                rem_q <= trial_d[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= shifted_d[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign div_done  = run_q && (cnt_q == CW'(1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator controller: button edge detect, operand latch, one-op sequencing on the accumulator.
// Define CALC_SEQ_BTN_SYNC_EN to put a 2-flop synchronizer in front of the button edge detect.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for a button rise
//  EXEC    | operands latched; single-cycle ops write, DIV/MOD start divider
//  DIVW    | divider iterating
//  WB      | divider result written to accumulator
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              button,
    input  logic [2:0]        func,
    input  logic [IN_W-1:0]   num1,
    input  logic [IN_W-1:0]   num2,
    output logic [DATA_W-1:0] result,
    output logic              acc_valid,
    output logic              busy,
    output logic              done,
    output logic              err_div0,
    output logic [CNT_W-1:0]  op_count
);

    logic btn_in;

`ifdef CALC_SEQ_BTN_SYNC_EN
    logic btn_s1_q;
    logic btn_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            btn_s1_q <= button;
            btn_s2_q <= btn_s1_q;
        end
    end

    assign btn_in = btn_s2_q;
`else
    assign btn_in = button;
`endif

    state_t              state_q;
    logic                button_q;
    logic [2:0]          func_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   result_q;
    logic                acc_valid_q;
    logic                done_q;
    logic                err_div0_q;
    logic [CNT_W-1:0]    op_count_q;

    logic                rise_d;
    logic                div_start_d;
    logic [DATA_W-1:0]   alu_d;
    logic [DATA_W-1:0]   quotient;
    logic [DATA_W-1:0]   remainder;
    logic                div_done;

    assign rise_d      = btn_in & ~button_q;
    assign div_start_d = (state_q == ST_EXEC) && is_div_op(func_q) && (b_q != '0);

    always_comb begin
        alu_d = result_q;
        unique case (func_q)
            OP_ADD:  alu_d = a_q + b_q;
            OP_SUB:  alu_d = a_q - b_q;
            OP_MUL:  alu_d = a_q * b_q;
            OP_SQR:  alu_d = a_q * a_q;
            OP_CLR:  alu_d = '0;
            default: alu_d = result_q;
        endcase
    end

    calc_seq_divider #(
        .W(DATA_W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start_d),
        .dividend  (a_q),
        .divisor   (b_q),
        .quotient  (quotient),
        .remainder (remainder),
        .div_done  (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            button_q    <= 1'b0;
            func_q      <= OP_NOP;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            acc_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_div0_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            button_q <= btn_in;
            done_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // Rises outside IDLE are dropped, not queued.
                    if (rise_d) begin
                        func_q     <= func;
                        a_q        <= acc_valid_q ? result_q : DATA_W'(num1);
                        b_q        <= DATA_W'(num2);
                        err_div0_q <= 1'b0;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_div_op(func_q)) begin
                        if (b_q == '0) begin
                            err_div0_q <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_DIVW;
                        end
                    end else begin
                        result_q <= alu_d;
                        if (sets_acc_valid(func_q)) begin
                            acc_valid_q <= 1'b1;
                        end else if (func_q == OP_CLR) begin
                            acc_valid_q <= 1'b0;
                        end
                        done_q     <= 1'b1;
                        op_count_q <= op_count_q + CNT_W'(1);
                        state_q    <= ST_IDLE;
                    end
                end
                ST_DIVW: begin
                    if (div_done) begin
                        state_q <= ST_WB;
                    end
                end
                ST_WB: begin
                    result_q    <= (func_q == OP_DIV) ? quotient : remainder;
                    acc_valid_q <= 1'b1;
                    done_q      <= 1'b1;
                    op_count_q  <= op_count_q + CNT_W'(1);
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result    = result_q;
    assign acc_valid = acc_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err_div0  = err_div0_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: directed presses push expected results, a monitor checks on done.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        button;
    logic [2:0]  func;
    logic [7:0]  num1;
    logic [7:0]  num2;
    logic [31:0] result;
    logic        acc_valid;
    logic        busy;
    logic        done;
    logic        err_div0;
    logic [15:0] op_count;

    calc_op_sequencer #(
        .IN_W   (8),
        .DATA_W (32),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .button    (button),
        .func      (func),
        .num1      (num1),
        .num2      (num2),
        .result    (result),
        .acc_valid (acc_valid),
        .busy      (busy),
        .done      (done),
        .err_div0  (err_div0),
        .op_count  (op_count)
    );

    typedef struct {
        logic [31:0] res;
        logic        av;
        logic        err;
        logic [15:0] cnt;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result",    result,    e.res);
                    chk("acc_valid", acc_valid, e.av);
                    chk("err_div0",  err_div0,  e.err);
                    chk("op_count",  op_count,  e.cnt);
                    chk("latency",   cyc - e.acc, e.lat);
                end
            end
        end
    end

    task automatic press(input logic [2:0] f, input logic [7:0] n1, input logic [7:0] n2,
                         input int hold, input bit repress,
                         input logic [31:0] er, input logic ea, input logic ee,
                         input logic [15:0] ec, input int lat);
        exp_t e;
        int   k;
        int   bc;
        bit   fin;
        func = f;
        num1 = n1;
        num2 = n2;
        @(negedge clk);
        e.res = er; e.av = ea; e.err = ee; e.cnt = ec; e.acc = cyc + 1; e.lat = lat;
        sb.push_back(e);
        button = 1'b1;
        k = 0; bc = 0; fin = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                func = OP_CLR;
                num1 = 8'hAA;
                num2 = 8'h00;
            end
            if (!fin) begin
                if (busy) bc++;
                else fin = 1'b1;
            end
            if (k == hold) button = 1'b0;
            if (repress && k == 8)  button = 1'b1;
            if (repress && k == 10) button = 1'b0;
            if (fin && k >= hold && k >= 12) break;
        end
        if (!fin) chk("busy_timeout", 0, 1);
        else chk("busy_cycles", bc, lat);
        button = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        button = 1'b0;
        func   = OP_NOP;
        num1   = 8'd0;
        num2   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result",    result,    0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_done",      done,      0);
        chk("rst_err",       err_div0,  0);
        chk("rst_op_count",  op_count,  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        //     func    num1   num2  hold rep  result          av    err   cnt  lat
        press(OP_ADD, 8'd12, 8'd5,  1, 0, 32'd17,         1'b1, 1'b0, 16'd1, 1);
        press(OP_SUB, 8'd99, 8'd20, 1, 0, 32'hFFFF_FFFD,  1'b1, 1'b0, 16'd2, 1);
        press(OP_MUL, 8'd99, 8'd3,  1, 0, 32'hFFFF_FFF7,  1'b1, 1'b0, 16'd3, 1);
        press(OP_CLR, 8'd0,  8'd0,  1, 0, 32'd0,          1'b0, 1'b0, 16'd4, 1);
        press(OP_DIV, 8'd100, 8'd7, 1, 0, 32'd14,         1'b1, 1'b0, 16'd5, 34);
        press(OP_MOD, 8'd50, 8'd4,  1, 0, 32'd2,          1'b1, 1'b0, 16'd6, 34);
        press(OP_DIV, 8'd50, 8'd0,  1, 0, 32'd2,          1'b1, 1'b1, 16'd6, 1);
        press(OP_NOP, 8'd50, 8'd9,  1, 0, 32'd2,          1'b1, 1'b0, 16'd7, 1);
        press(OP_SQR, 8'd50, 8'd9,  1, 0, 32'd4,          1'b1, 1'b0, 16'd8, 1);
        press(OP_DIV, 8'd50, 8'd3,  2, 1, 32'd1,          1'b1, 1'b0, 16'd9, 34);
        repeat (40) @(negedge clk);
        chk("repress_ignored_busy",  busy,     0);
        chk("repress_ignored_count", op_count, 9);
        press(OP_ADD, 8'd50, 8'd10, 10, 0, 32'd11,        1'b1, 1'b0, 16'd10, 1);
        repeat (10) @(negedge clk);
        chk("held_one_op", op_count, 10);

        // Abort a division mid-flight with reset.
        func = OP_DIV;
        num1 = 8'd1;
        num2 = 8'd2;
        @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        repeat (10) @(negedge clk);
        chk("div_in_flight", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_result",    result,    0);
        chk("abort_acc_valid", acc_valid, 0);
        chk("abort_busy",      busy,      0);
        chk("abort_done",      done,      0);
        chk("abort_err",       err_div0,  0);
        chk("abort_op_count",  op_count,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", busy, 0);
        press(OP_ADD, 8'd9, 8'd1,   1, 0, 32'd10,         1'b1, 1'b0, 16'd1, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
